// File: rtl/palu_pkg.sv
// Shared op encoding for the pipelined ALU.
package palu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_NOTB = 3'd1;
    localparam op_t OP_AND  = 3'd2;
    localparam op_t OP_OR   = 3'd3;
    localparam op_t OP_SUB  = 3'd4;
    localparam op_t OP_XOR  = 3'd5;
    localparam op_t OP_SHL  = 3'd6;
    localparam op_t OP_SHR  = 3'd7;

endpackage

// File: rtl/palu_core.sv
// Combinational ALU datapath: result, carry/borrow/lost-bits flag, zero and negative.
module palu_core
    import palu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  op_t          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] f,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int unsigned SW = $clog2(W);

    logic [SW-1:0]  sh_amt;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] shl_wide;
    logic [2*W-1:0] shr_wide;

    // Shifts run in a double-width window so the lost bits land in the spare half.
    always_comb begin
        sh_amt   = b[SW-1:0];
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        shl_wide = {{W{1'b0}}, a} << sh_amt;
        shr_wide = {a, {W{1'b0}}} >> sh_amt;
    end

    always_comb begin
        f   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                f   = sum[W-1:0];
                ovf = sum[W];
            end
            OP_NOTB: f = ~b;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_SUB: begin
                f   = diff[W-1:0];
                ovf = diff[W];
            end
            OP_XOR:  f = a ^ b;
            OP_SHL: begin
                f   = shl_wide[W-1:0];
                ovf = |shl_wide[2*W-1:W];
            end
            OP_SHR: begin
                f   = shr_wide[2*W-1:W];
                ovf = |shr_wide[W-1:0];
            end
            default: begin
                f   = '0;
                ovf = 1'b0;
            end
        endcase
    end

    assign zero = (f == '0);
    assign neg  = f[W-1];

endmodule

// File: rtl/palu_pipe.sv
// Two-stage valid/ready ALU pipeline with sticky overflow and saturating overflow counter.
module palu_pipe
    import palu_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  op_t           op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  f,
    output logic          ovf,
    output logic          zero,
    output logic          neg,
    output logic          ovf_sticky,
    output logic [CW-1:0] ovf_count,
    input  logic          ovf_clr
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic         s1_valid;
    op_t          s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;

    logic         adv1;
    logic         adv2;
    logic         ovf_event;

    logic [W-1:0] core_f_c;
    logic         core_ovf_c;
    logic         core_zero_c;
    logic         core_neg_c;

    // Stage advance depends only on registered state and out_ready.
    assign adv2      = !out_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign ovf_event = out_valid && out_ready && ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end
        end
    end

    palu_core #(
        .W (W)
    ) u_core (
        .op   (s1_op),
        .a    (s1_a),
        .b    (s1_b),
        .f    (core_f_c),
        .ovf  (core_ovf_c),
        .zero (core_zero_c),
        .neg  (core_neg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f    <= core_f_c;
                ovf  <= core_ovf_c;
                zero <= core_zero_c;
                neg  <= core_neg_c;
            end
        end
    end

    // A delivered overflow beats a same-cycle clear: the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
            if (ovf_clr) begin
                ovf_count <= CW'(1);
            end else if (ovf_count != CNT_MAX) begin
                ovf_count <= ovf_count + CW'(1);
            end
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end
    end

endmodule

// File: tb/tb_palu_pipe.sv
// Randomized and directed checks of palu_pipe against a queue-based reference model.
module tb_palu_pipe;

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  f;
    logic          ovf;
    logic          zero;
    logic          neg;
    logic          ovf_sticky;
    logic [CW-1:0] ovf_count;
    logic          ovf_clr;

    palu_pipe #(.W(W), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .f          (f),
        .ovf        (ovf),
        .zero       (zero),
        .neg        (neg),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic       ovf;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_idx = 0;
    int   n_dlv = 0;
    int   cnt_m = 0;
    bit   sticky_m = 1'b0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference result {ovf, f} from plain integer arithmetic.
    function automatic logic [8:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int xi;
        int yi;
        int s;
        int r;
        xi = int'(x);
        yi = int'(y);
        s  = yi % 8;
        case (o)
            3'd0: begin r = xi + yi; return 9'(r); end
            3'd1: return {1'b0, ~y};
            3'd2: return {1'b0, x & y};
            3'd3: return {1'b0, x | y};
            3'd4: return {xi < yi, 8'(xi - yi)};
            3'd5: return {1'b0, x ^ y};
            3'd6: begin r = xi << s; return {(r >> 8) != 0, 8'(r)}; end
            default: return {(xi % (1 << s)) != 0, 8'(xi >> s)};
        endcase
    endfunction

    // One clock cycle: drive, check against model, take the edge, advance model.
    task automatic step(input logic iv, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic ordy, input logic clr, input logic [8:0] eres);
        bit   rdy_e;
        bit   ov_e;
        bit   acc;
        bit   dlv;
        bit   evt;
        exp_t ent;
        in_valid  = iv;
        op        = o;
        a         = x;
        b         = y;
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        rdy_e = (q.size() < 2) || ordy;
        ov_e  = (q.size() > 0) && (q[0].acc < edge_idx);
        chk("in_ready", 32'(in_ready), 32'(rdy_e));
        chk("out_valid", 32'(out_valid), 32'(ov_e));
        if (ov_e) begin
            chk("f", 32'(f), 32'(q[0].f));
            chk("ovf", 32'(ovf), 32'(q[0].ovf));
            chk("zero", 32'(zero), 32'(q[0].f == 8'h00));
            chk("neg", 32'(neg), 32'(q[0].f[7]));
        end
        chk("ovf_sticky", 32'(ovf_sticky), 32'(sticky_m));
        chk("ovf_count", 32'(ovf_count), 32'(cnt_m));
        acc = iv && rdy_e;
        dlv = ov_e && ordy;
        evt = dlv && q[0].ovf;
        @(posedge clk);
        edge_idx++;
        if (dlv) begin
            ent = q.pop_front();
            n_dlv++;
        end
        if (acc) q.push_back('{f: eres[7:0], ovf: eres[8], acc: edge_idx});
        if (evt) begin
            sticky_m = 1'b1;
            cnt_m    = clr ? 1 : ((cnt_m < CMAX) ? cnt_m + 1 : cnt_m);
        end else if (clr) begin
            sticky_m = 1'b0;
            cnt_m    = 0;
        end
        last_acc = acc;
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 9'h000);
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [2:0] d_op [11] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    logic [7:0] d_a  [11] = '{8'h01, 8'h54, 8'hAB, 8'h00, 8'hFF, 8'h55, 8'h10, 8'hF0, 8'h81, 8'h03, 8'h5A};
    logic [7:0] d_b  [11] = '{8'h00, 8'hAA, 8'h55, 8'hAA, 8'hFF, 8'hAA, 8'h20, 8'hFF, 8'h01, 8'h01, 8'h08};
    logic [8:0] d_e  [11] = '{9'h001, 9'h0FE, 9'h100, 9'h055, 9'h0FF, 9'h0FF, 9'h1F0, 9'h00F, 9'h102, 9'h101, 9'h05A};

    initial begin
        int         idx;
        int         acc_stall;
        int         dlv0;
        int         guard;
        logic [2:0] ro;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with expected values written out by hand.
        for (int i = 0; i < 11; i++)
            step(1'b1, d_op[i], d_a[i], d_b[i], 1'b1, 1'b0, d_e[i]);
        drain();

        // Backpressure: six ops offered back to back, consumer stalled four cycles.
        dlv0      = n_dlv;
        idx       = 0;
        acc_stall = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 3'd0, 8'(idx), 8'h10, 1'b0, 1'b0, ref_op(3'd0, 8'(idx), 8'h10));
            if (last_acc) begin
                idx++;
                acc_stall++;
            end
        end
        chk("stall_accepts", 32'(acc_stall), 32'd2);
        guard = 0;
        while (idx < 6 && guard < 20) begin
            step(1'b1, 3'd0, 8'(idx), 8'h10, 1'b1, 1'b0, ref_op(3'd0, 8'(idx), 8'h10));
            if (last_acc) idx++;
            guard++;
        end
        drain();
        chk("bp_delivered", 32'(n_dlv - dlv0), 32'd6);

        // Saturation with a 2-bit counter, then clear colliding with a delivery.
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 9'h000);
        for (int i = 0; i < 5; i++)
            step(1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 9'h100);
        drain();
        chk("sat_count", 32'(ovf_count), 32'd3);
        chk("sat_sticky", 32'(ovf_sticky), 32'd1);
        step(1'b1, 3'd0, 8'hFF, 8'h01, 1'b1, 1'b0, 9'h100);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000);
        step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 9'h000);
        chk("clr_evt_count", 32'(ovf_count), 32'd1);
        chk("clr_evt_sticky", 32'(ovf_sticky), 32'd1);

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            step(1'($urandom_range(0, 3) != 0), ro, ra, rb, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0), ref_op(ro, ra, rb));
        end

        // Fill the pipe, then reset mid-stream.
        for (int i = 0; i < 3; i++)
            step(1'b1, 3'd0, 8'hF0, 8'h20, 1'b0, 1'b0, ref_op(3'd0, 8'hF0, 8'h20));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(ovf_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        cnt_m    = 0;
        sticky_m = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        edge_idx++;
        #1;
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 9'h000);
        step(1'b1, 3'd4, 8'h10, 8'h20, 1'b1, 1'b0, 9'h1F0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/palu_pipe.md
# palu_pipe

Parametrised, pipelined successor of the 8-bit arithmetic/logic unit. It accepts one operation per cycle through a valid/ready handshake and runs it through a two-stage pipeline with full backpressure. It returns a W-bit result with carry/overflow, zero and negative flags, and keeps a sticky overflow status plus a saturating overflow event counter. It sits between an operand sequencer and a result consumer, both of which may stall.

## Interface
- W, default 8: operand and result width; must be at least 2 and a power of two.
- CW, default 8: width of the overflow event counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  the operation on op, a and b is valid.
- in_ready  out  1  the block accepts an operation this cycle.
- op  in  3  operation select; encoding given under Operation.
- a  in  W  first operand.
- b  in  W  second operand.
- out_valid  out  1  the result on f and the flags is valid.
- out_ready  in  1  the consumer accepts the result this cycle.
- f  out  W  result.
- ovf  out  1  carry, borrow or lost-bits flag.
- zero  out  1  f == 0.
- neg  out  1  f[W-1].
- ovf_sticky  out  1  at least one overflow has been delivered since the last clear.
- ovf_count  out  CW  number of delivered overflows, saturating.
- ovf_clr  in  1  clears ovf_sticky and ovf_count.

## Operation
- Op encoding. Codes 0 to 3 keep the legacy 2-bit encoding.
  - 0 ADD: {ovf,f} = a + b, computed at W+1 bits; ovf is the unsigned carry-out.
  - 1 NOTB: f = ~b; ovf = 0.
  - 2 AND: f = a & b; ovf = 0.
  - 3 OR: f = a | b; ovf = 0.
  - 4 SUB: f = a - b, modulo 2^W; ovf = 1 when a < b, compared unsigned (borrow).
  - 5 XOR: f = a ^ b; ovf = 0.
  - 6 SHL: f = a << s, where s = b[log2(W)-1:0]; ovf = OR of the bits shifted out; s = 0 gives ovf = 0.
  - 7 SHR: logical right shift by s; ovf = OR of the bits shifted out.
- zero and neg are derived from f only, whatever the op.
- Stage 1 (S1) registers op, a and b.
- Stage 2 (S2) registers f, ovf, zero and neg, computed from the S1 contents.
- Advance rules:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. It is registered-path combinational, with no combinational path from in_valid.
- S1 and S2 each hold their contents while stalled; no operation is lost or duplicated.
- Overflow event: out_valid && out_ready && ovf, i.e. counted when the result is delivered, not when it is computed.
  - On an event, ovf_sticky sets and ovf_count increments, saturating at 2^CW-1.
  - On ovf_clr alone, ovf_sticky becomes 0 and ovf_count becomes 0.
  - On ovf_clr and an event in the same cycle, the event wins: ovf_sticky = 1 and ovf_count = 1.

## Timing
- Reset values: s1_valid = 0, out_valid = 0, f = 0, ovf = 0, zero = 0, neg = 0, ovf_sticky = 0, ovf_count = 0. in_ready reads 1 during and after reset.
- Reset mid-operation drops every in-flight operation; nothing is presented after reset is released.
- Latency: an op accepted at edge N appears on the outputs after edge N+1 when no stall occurs.
- Throughput is one op per cycle while out_ready is held high.
- Outputs hold stable while out_valid && !out_ready.
- With the pipeline full and out_ready low, in_ready = 0. When out_ready rises, in_ready rises in the same cycle.
- ovf_sticky and ovf_count update on the edge that completes the output handshake.

## Structure
- Package palu_pkg holds:
  - the op encoding constants OP_ADD, OP_NOTB, OP_AND, OP_OR, OP_SUB, OP_XOR, OP_SHL, OP_SHR;
  - the 3-bit op typedef.
- Sub-module palu_core, parameter W: purely combinational; inputs op, a and b; outputs f, ovf, zero and neg.
- palu_pipe instantiates palu_core once between S1 and S2 and owns the handshake, the pipeline registers and the overflow status.

## Test plan
- Reset: assert rst_n low mid-stream -> out_valid = 0, ovf_count = 0 and in_ready = 1 immediately; no stale result after release.
- Legacy ops with W = 8 and out_ready held high:
  - ADD 0x01 + 0x00 -> f = 0x01, ovf = 0.
  - ADD 0x54 + 0xAA -> f = 0xFE.
  - ADD 0xAB + 0x55 -> f = 0x00, ovf = 1, zero = 1.
  - NOTB b = 0xAA -> f = 0x55.
  - AND 0xFF & 0xFF -> f = 0xFF, neg = 1.
  - OR 0x55 | 0xAA -> f = 0xFF.
  - Each result arrives 2 cycles after acceptance.
- New ops:
  - SUB 0x10 - 0x20 -> f = 0xF0, ovf = 1.
  - XOR 0xF0 ^ 0xFF -> f = 0x0F.
  - SHL 0x81 by 1 -> f = 0x02, ovf = 1.
  - SHR 0x03 by 1 -> f = 0x01, ovf = 1.
  - SHL by 0 -> f = a, ovf = 0.
- Backpressure:
  - Drive 6 back-to-back ops with out_ready low for 4 cycles -> in_ready drops after 2 acceptances.
  - Then release out_ready -> all 6 results delivered in order, none dropped or repeated.
- Counter:
  - CW = 2 with 5 overflowing ADDs delivered -> ovf_count saturates at 3, ovf_sticky = 1.
  - ovf_clr in the same cycle as an overflow delivery -> ovf_count = 1.
